// File: rtl/y86_mem_pkg.sv
// Shared definitions for the Y86 data-memory port: FSM states, word size,
// default memory size and the icode-to-direction mapping used by the
// memory stage to decide whether an access is a store or a load.
package y86_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  localparam int WORD_BYTES    = 8;
  localparam int DEF_MEM_BYTES = 1024;

  // Y86-64 instruction codes that touch data memory
  localparam logic [3:0] IC_RMMOVQ = 4'h4;
  localparam logic [3:0] IC_MRMOVQ = 4'h5;
  localparam logic [3:0] IC_CALL   = 4'h8;
  localparam logic [3:0] IC_RET    = 4'h9;
  localparam logic [3:0] IC_PUSHQ  = 4'hA;
  localparam logic [3:0] IC_POPQ   = 4'hB;

  // Stores: rmmovq, call, pushq
  function automatic logic icode_is_store(input logic [3:0] icode);
    return (icode == IC_RMMOVQ) || (icode == IC_CALL) || (icode == IC_PUSHQ);
  endfunction

  // Loads: mrmovq, ret, popq
  function automatic logic icode_is_load(input logic [3:0] icode);
    return (icode == IC_MRMOVQ) || (icode == IC_RET) || (icode == IC_POPQ);
  endfunction

endpackage

// File: rtl/mem_byte_master_if.sv
// Request/response and byte-bus signals of the data-memory initiator.
// The master modport is the initiator's view; slave is the view of the
// environment (pipeline requester plus byte RAM).
interface mem_byte_master_if #(
  parameter int ADDR_W = 10
) ();

  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [63:0]       req_addr_i;
  logic [63:0]       req_wdata_i;

  logic              resp_valid_o;
  logic [63:0]       resp_rdata_o;
  logic              resp_error_o;

  logic              bus_req_o;
  logic              bus_we_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [7:0]        bus_wdata_o;
  logic              bus_ack_i;
  logic [7:0]        bus_rdata_i;

  modport master (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i,
    input  bus_ack_i, bus_rdata_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_error_o,
    output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o
  );

  modport slave (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i,
    output bus_ack_i, bus_rdata_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_error_o,
    input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o
  );

endinterface

// File: rtl/mem_byte_master.sv
// Byte-serial memory initiator: one 64-bit load/store is run as eight
// little-endian byte beats over a req/ack byte bus, then answered with a
// single-cycle response. Out-of-range addresses are answered with an error
// without touching the bus. All outputs decode from registered state only.
module mem_byte_master
  import y86_mem_pkg::*;
#(
  parameter int MEM_BYTES = DEF_MEM_BYTES,
  parameter int ADDR_W    = 10
) (
  input  logic            clk_i,
  input  logic            rst_i,
  mem_byte_master_if.master mif
);

  // Highest base address whose eight bytes still fit in memory
  localparam logic [63:0] LAST_BASE = 64'(MEM_BYTES - WORD_BYTES);

  state_t            state;
  state_t            state_nx;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [63:0]       wbuf;
  logic [63:0]       rbuf;
  logic [2:0]        beat;
  logic              addr_bad;
  logic              beat_done;

  // Request range check and beat completion qualifier
  always_comb begin
    addr_bad  = mif.req_addr_i > LAST_BASE;
    beat_done = (state == ST_XFER) && mif.bus_ack_i;
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Next-state decode; requests are only looked at in IDLE
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (mif.req_valid_i) state_nx = addr_bad ? ST_ERR : ST_XFER;
      ST_XFER: if (mif.bus_ack_i && (beat == 3'd7)) state_nx = ST_RESP;
      ST_RESP: state_nx = ST_IDLE;
      ST_ERR:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Request capture, beat counter and read-byte assembly
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_r   <= 1'b0;
      addr_r <= '0;
      wbuf   <= '0;
      rbuf   <= '0;
      beat   <= '0;
    end else if ((state == ST_IDLE) && mif.req_valid_i) begin
      we_r   <= mif.req_we_i;
      addr_r <= mif.req_addr_i[ADDR_W-1:0];
      wbuf   <= mif.req_wdata_i;
      rbuf   <= '0;
      beat   <= '0;
    end else if (beat_done) begin
      if (!we_r) rbuf[8*beat +: 8] <= mif.bus_rdata_i;
      // Beat 7 is the last one; the counter never wraps
      if (beat != 3'd7) beat <= beat + 3'd1;
    end
  end

  // Output decode: bus and response fields are zero outside their states
  always_comb begin
    mif.req_ready_o  = 1'b0;
    mif.resp_valid_o = 1'b0;
    mif.resp_error_o = 1'b0;
    mif.resp_rdata_o = '0;
    mif.bus_req_o    = 1'b0;
    mif.bus_we_o     = 1'b0;
    mif.bus_addr_o   = '0;
    mif.bus_wdata_o  = '0;
    case (state)
      ST_IDLE: mif.req_ready_o = 1'b1;
      ST_XFER: begin
        mif.bus_req_o   = 1'b1;
        mif.bus_we_o    = we_r;
        mif.bus_addr_o  = addr_r + ADDR_W'(beat);
        mif.bus_wdata_o = wbuf[8*beat +: 8];
      end
      ST_RESP: begin
        mif.resp_valid_o = 1'b1;
        mif.resp_rdata_o = we_r ? 64'd0 : rbuf;
      end
      ST_ERR: begin
        mif.resp_valid_o = 1'b1;
        mif.resp_error_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
